// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma-aligned MSB-first deserialiser on the bit clock.
// Optional idle-byte counter output enabled by defining SP_COMMA_CNT_EN.
module serial_paralelo #(
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter int         COMMA_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
`ifdef SP_COMMA_CNT_EN
   ,
   output logic [7:0] idle_count
`endif
);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_ALIGNED,
      ST_ACTIVE
   } state_t;

   localparam logic [3:0] COMMA_TGT = 4'(COMMA_COUNT);

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t     state_q;
   // Only the 7 most recent bits need storing; the 8th is the live input.
   logic [6:0] sr_q;
   logic [2:0] bit_cnt_q;
   logic [3:0] comma_cnt_q;
   logic [7:0] data_q;
   logic       valid_q;
   logic       active_q;
   logic [7:0] nb_d;
   logic [3:0] comma_cnt_d;
   logic       boundary;
   logic       is_comma;

   assign nb_d        = {sr_q, data_in};
   assign comma_cnt_d = sat_inc4(comma_cnt_q);
   assign boundary    = (bit_cnt_q == 3'd7);
   assign is_comma    = (nb_d == COMMA);

`ifdef SP_COMMA_CNT_EN
   logic [7:0] idle_q;
   assign idle_count = idle_q;
`endif

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_HUNT;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         active_q    <= 1'b0;
`ifdef SP_COMMA_CNT_EN
         idle_q      <= '0;
`endif
      end else begin
         sr_q <= nb_d[6:0];
         case (state_q)
            ST_HUNT: begin
               if (is_comma) begin
                  bit_cnt_q   <= '0;
                  comma_cnt_q <= 4'd1;
                  if (COMMA_COUNT == 1) begin
                     state_q  <= ST_ACTIVE;
                     active_q <= 1'b1;
                  end else begin
                     state_q <= ST_ALIGNED;
                  end
               end
            end
            ST_ALIGNED: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (boundary) begin
                  if (is_comma) begin
                     comma_cnt_q <= comma_cnt_d;
                     if (comma_cnt_d == COMMA_TGT) begin
                        state_q  <= ST_ACTIVE;
                        active_q <= 1'b1;
                     end
                  end else begin
                     // Misaligned or premature data: restart the bit-level search.
                     state_q     <= ST_HUNT;
                     comma_cnt_q <= '0;
                  end
               end
            end
            ST_ACTIVE: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (boundary) begin
                  if (is_comma) begin
                     valid_q <= 1'b0;
`ifdef SP_COMMA_CNT_EN
                     idle_q  <= sat_inc8(idle_q);
`endif
                  end else begin
                     data_q  <= nb_d;
                     valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_HUNT;
         endcase
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = active_q;

`ifndef SP_COMMA_CNT_EN
   // sat_inc8 only serves the optional idle counter.
   logic [7:0] unused_sat8;
   assign unused_sat8 = sat_inc8(8'h00);
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed self-checking bench for serial_paralelo (comma alignment, data delivery, reset).
// Idle counter checks are included when SP_COMMA_CNT_EN is defined.
module tb_serial_paralelo;

   logic       clk_32f;
   logic       reset;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
`ifdef SP_COMMA_CNT_EN
   logic [7:0] idle_count;
`endif

   int errors = 0;
   int checks = 0;

   serial_paralelo dut (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
`ifdef SP_COMMA_CNT_EN
      ,
      .idle_count(idle_count)
`endif
   );

   initial begin
      clk_32f = 1'b0;
      forever #5 clk_32f = ~clk_32f;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
      $fatal(1);
   end

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      reset = 1'b0;
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         checks++;
         if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got data=%h valid=%b active=%b, want 00 0 0", data_out, valid_out, active);
         end
      end
      @(negedge clk_32f);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_bit(1'b0);
         checks++;
         if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got data=%h valid=%b active=%b, want 00 0 0", data_out, valid_out, active);
         end
      end
   endtask

   task automatic test_unaligned_hunt();
      logic [7:0] seq [3];
      logic [7:0] prev_d;
      logic       prev_v;
      seq = '{8'hFF, 8'hEE, 8'hDD};
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL hunt_3rd_comma: got active=%b, want 0", active);
      end
      send_byte(8'hBC);
      checks++;
      if (active !== 1'b1 || valid_out !== 1'b0 || data_out !== 8'h00) begin
         errors++;
         $display("FAIL hunt_4th_comma: got active=%b valid=%b data=%h, want 1 0 00", active, valid_out, data_out);
      end
      prev_d = 8'h00;
      prev_v = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 7; i >= 1; i--) begin
            send_bit(seq[k][i]);
            checks++;
            if (data_out !== prev_d || valid_out !== prev_v) begin
               errors++;
               $display("FAIL hunt_hold_%0d: got data=%h valid=%b, want %h %b", k, data_out, valid_out, prev_d, prev_v);
            end
         end
         send_bit(seq[k][0]);
         checks++;
         if (data_out !== seq[k] || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL hunt_byte_%0d: got data=%h valid=%b, want %h 1", k, data_out, valid_out, seq[k]);
         end
         prev_d = seq[k];
         prev_v = 1'b1;
      end
   endtask

   task automatic test_too_few_commas();
      do_reset();
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      send_byte(8'h55);
      checks++;
      if (active !== 1'b0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL few_after_55: got active=%b valid=%b, want 0 0", active, valid_out);
      end
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL few_realign_3: got active=%b, want 0", active);
      end
      send_byte(8'hBC);
      checks++;
      if (active !== 1'b1) begin
         errors++;
         $display("FAIL few_realign_4: got active=%b, want 1", active);
      end
      send_byte(8'hAA);
      checks++;
      if (data_out !== 8'hAA || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL few_data_aa: got data=%h valid=%b, want AA 1", data_out, valid_out);
      end
   endtask

   task automatic test_idle_in_data();
      send_byte(8'hAA);
      checks++;
      if (data_out !== 8'hAA || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL idle_aa: got data=%h valid=%b, want AA 1", data_out, valid_out);
      end
      send_byte(8'hBC);
      checks++;
      if (data_out !== 8'hAA || valid_out !== 1'b0 || active !== 1'b1) begin
         errors++;
         $display("FAIL idle_bc: got data=%h valid=%b active=%b, want AA 0 1", data_out, valid_out, active);
      end
      send_byte(8'hCC);
      checks++;
      if (data_out !== 8'hCC || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL idle_cc: got data=%h valid=%b, want CC 1", data_out, valid_out);
      end
   endtask

   task automatic test_mid_reset();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: got data=%h valid=%b active=%b, want 00 0 0", data_out, valid_out, active);
      end
      @(negedge clk_32f);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         send_byte(8'hBB);
         checks++;
         if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_bb_%0d: got data=%h valid=%b active=%b, want 00 0 0", k, data_out, valid_out, active);
         end
      end
   endtask

`ifdef SP_COMMA_CNT_EN
   task automatic test_idle_count();
      do_reset();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      checks++;
      if (active !== 1'b1 || idle_count !== 8'd0) begin
         errors++;
         $display("FAIL idlecnt_align: got active=%b idle=%0d, want 1 0", active, idle_count);
      end
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h11);
      send_byte(8'hBC);
      checks++;
      if (idle_count !== 8'd3 || data_out !== 8'h11 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL idlecnt_final: got idle=%0d data=%h valid=%b, want 3 11 0", idle_count, data_out, valid_out);
      end
   endtask
`endif

   initial begin
      reset   = 1'b0;
      data_in = 1'b0;
      test_reset();
      test_unaligned_hunt();
      test_too_few_commas();
      test_idle_in_data();
      test_mid_reset();
`ifdef SP_COMMA_CNT_EN
      test_idle_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive end of the serial link: deserialises the MSB-first bit stream produced by paralelo_serial back into bytes.
- Runs on the fast bit clock only; byte boundaries are recovered internally by comma (idle byte) alignment.
- Sits downstream of the serial line, ahead of the clk_4f byte-domain logic; its outputs are bit-clock registered and held stable for 8 bit periods.

Parameters:
- COMMA, 8'hBC, idle/alignment byte the transmitter sends while valid_in=0.
- COMMA_COUNT, 4, consecutive aligned commas required before going active; legal range 1..15.

Ports:
- clk_32f  input  1  bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  1  serial bit, MSB of each byte first, one bit per clk_32f.
- data_out  output  8  last received non-comma byte.
- valid_out  output  1  1 while data_out holds a byte from the current 8-bit slot.
- active  output  1  link aligned and active; sticky until reset.

Behaviour:
- Reset (async assert, sync release): data_out=8'h00, valid_out=0, active=0, shift reg=0, bit_cnt=0, comma_cnt=0, state=HUNT.
- Shift: every posedge, sr <= {sr[6:0], data_in}. Candidate byte nb = {sr[6:0], data_in}, combinational.
- HUNT: check nb==COMMA on every bit. On match: bit_cnt<=0, comma_cnt<=1. If COMMA_COUNT==1, go ACTIVE, else go ALIGNED. Outputs stay at reset values.
- Byte boundary: in ALIGNED/ACTIVE, bit_cnt increments 0..7 and wraps. The byte completes on the edge where bit_cnt==7; that byte is nb.
- ALIGNED, at boundary:
  - nb==COMMA: comma_cnt++. When the new count equals COMMA_COUNT, go ACTIVE and set active<=1 on this same edge.
  - nb!=COMMA: go HUNT, comma_cnt<=0. Bit-level search restarts on the next bit.
- ACTIVE, at boundary:
  - nb!=COMMA: data_out<=nb, valid_out<=1.
  - nb==COMMA: valid_out<=0, data_out holds its previous value.
  - Between boundaries both outputs hold.
- Latency: data_out/valid_out update on the edge sampling the byte's LSB. From the first data bit of a byte to valid output is 8 clk_32f edges.
- ACTIVE is never exited except by reset. Alignment is not re-checked once active (the transmitter is trusted).
- Comma matches at non-boundary bit positions are ignored in ALIGNED/ACTIVE.
- Reset asserted mid-byte or mid-alignment clears everything immediately. After release, the block must re-hunt and see COMMA_COUNT commas again.
- A byte equal to COMMA can never be delivered as data (reserved code).
- comma_cnt is 4 bits and saturates at 15 (matters only while ALIGNED).

Optional Feature:
- Macro: SP_COMMA_CNT_EN.
- Defined:
  - Extra output port idle_count [7:0], reset 0.
  - Increments by 1 at each ACTIVE byte boundary where nb==COMMA; saturates at 8'hFF.
  - Cleared only by reset. Counts only while active=1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 while driving random bits -> data_out=00, valid_out=0, active=0 throughout. Release -> nothing changes until commas arrive.
- Unaligned hunt: 3 junk bits (101), then 4×BC, then FF, EE, DD MSB-first:
  - active=1 on the LSB edge of the 4th BC.
  - data_out=FF/EE/DD with valid_out=1, each held 8 clk_32f cycles.
- Too few commas: 3×BC then 55 -> back to HUNT, active stays 0. Then 4×BC then AA -> active=1, data_out=AA.
- Idle inside data: in ACTIVE send AA, BC, CC -> data_out=AA valid=1; then valid=0 with data_out still AA; then CC valid=1.
- Mid-stream reset: pull reset low at bit 3 of a data byte -> outputs clear asynchronously the same instant. After release, BB without commas -> active=0, valid_out=0.
- With SP_COMMA_CNT_EN: align with 4×BC, then BC,BC,11,BC -> idle_count=3. Pre-active commas are not counted.
